// File: rtl/inst_fetch_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, runs one outstanding imem fetch at a time and
// holds the fetched word for decode until consumed.
//   state | meaning
//   REQ   | requesting imem at pc
//   WAIT  | granted, waiting for the response
//   VALID | instruction held for decode
//   DRAIN | flushed while a response is outstanding; discard it
//   HALT  | taken target was misaligned; wait for flush
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    inst_fetch_if.master       imem,
    output logic               o_inst_valid,
    input  logic               i_inst_ready,
    output logic [31:0]        o_inst,
    output logic [31:0]        o_inst_pc,
    output logic [6:0]         o_opcode,
    output logic [2:0]         o_func3,
    output logic               o_func7,
    input  logic               i_next_pc_sel,
    input  logic [31:0]        i_jb_target,
    input  logic               i_flush,
    input  logic [31:0]        i_flush_pc,
    output logic               o_fetch_misalign
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_VALID = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_pc,       w_pc_nxt;
    logic [31:0] r_inst,     w_inst_nxt;
    logic [31:0] r_inst_pc,  w_inst_pc_nxt;
    logic        r_misalign, w_misalign_nxt;

    logic [31:0] w_consume_pc;
    logic        w_tgt_misalign;

    assign w_consume_pc   = i_next_pc_sel ? (i_jb_target & 32'hFFFF_FFFE) : r_pc + 32'd4;
    assign w_tgt_misalign = i_next_pc_sel & i_jb_target[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_inst_pc_nxt  = r_inst_pc;
        w_misalign_nxt = r_misalign;

        case (r_state)
            S_REQ: begin
                if (i_flush)
                    w_state_nxt = imem.imem_gnt ? S_DRAIN : S_REQ;
                else if (imem.imem_gnt)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_state_nxt = imem.imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem.imem_rvalid) begin
                    w_state_nxt   = S_VALID;
                    w_inst_nxt    = imem.imem_rdata;
                    w_inst_pc_nxt = r_pc;
                end
            end
            S_VALID: begin
                if (i_flush) begin
                    w_state_nxt = S_REQ;
                end else if (i_inst_ready) begin
                    w_pc_nxt = w_consume_pc;
                    if (w_tgt_misalign) begin
                        w_state_nxt    = S_HALT;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            // A response arriving with a flush still retires the outstanding fetch.
            S_DRAIN: begin
                if (imem.imem_rvalid)
                    w_state_nxt = S_REQ;
            end
            S_HALT: begin
                if (i_flush)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (i_flush) begin
            w_pc_nxt       = i_flush_pc;
            w_inst_nxt     = NOP_INST;
            w_misalign_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_inst     <= NOP_INST;
            r_inst_pc  <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_inst_pc  <= w_inst_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // Request is masked while reset is held so no fetch escapes during reset.
    assign imem.imem_req  = (r_state == S_REQ) & i_rst_n;
    assign imem.imem_addr = r_pc;

    assign o_inst_valid     = (r_state == S_VALID);
    assign o_inst           = r_inst;
    assign o_inst_pc        = r_inst_pc;
    assign o_opcode         = r_inst[6:0];
    assign o_func3          = r_inst[14:12];
    assign o_func7          = r_inst[30];
    assign o_fetch_misalign = r_misalign;

endmodule
